// File: rtl/sound_mixer_pkg.sv
// Shared widths, register field positions, saturation limits and FSM encoding
// for the stereo sound mixer.
package sound_mixer_pkg;

    localparam int SAMPLE_W = 20;
    localparam int NUM_CH   = 4;
    localparam int ACC_W    = SAMPLE_W + 2;   // four channels summed without overflow
    localparam int PROD_W   = ACC_W + 3;      // accumulator times gain of at most 8
    localparam int VOL_W    = 3;

    localparam int NR50_L_LSB = 4;
    localparam int NR50_R_LSB = 0;
    localparam int NR51_L_LSB = 4;
    localparam int NR51_R_LSB = 0;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_SAT   = 2'd3
    } mix_state_t;

    function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [SAMPLE_W-1:0] s);
        return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/sound_mixer_if.sv
// Channel samples, sound registers and mixed stereo output of the sound mixer.
interface sound_mixer_if;
    import sound_mixer_pkg::*;

    logic                I_STROBE;
    logic [SAMPLE_W-1:0] I_CH1_WAVEFORM;
    logic [SAMPLE_W-1:0] I_CH2_WAVEFORM;
    logic [SAMPLE_W-1:0] I_CH3_WAVEFORM;
    logic [SAMPLE_W-1:0] I_CH4_WAVEFORM;
    logic [7:0]          I_NR50;
    logic [7:0]          I_NR51;
    logic                I_NR52_EN;
    logic [SAMPLE_W-1:0] O_LEFT;
    logic [SAMPLE_W-1:0] O_RIGHT;
    logic                O_VALID;
    logic                O_OVERRUN;

    modport master (
        output I_STROBE, I_CH1_WAVEFORM, I_CH2_WAVEFORM, I_CH3_WAVEFORM, I_CH4_WAVEFORM,
               I_NR50, I_NR51, I_NR52_EN,
        input  O_LEFT, O_RIGHT, O_VALID, O_OVERRUN
    );

    modport slave (
        input  I_STROBE, I_CH1_WAVEFORM, I_CH2_WAVEFORM, I_CH3_WAVEFORM, I_CH4_WAVEFORM,
               I_NR50, I_NR51, I_NR52_EN,
        output O_LEFT, O_RIGHT, O_VALID, O_OVERRUN
    );

endinterface

// File: rtl/sound_mix_scale_sat.sv
// Combinational master-volume stage: acc * (vol + 1), arithmetic >>> 3,
// then clamp to the signed output sample range.
module sound_mix_scale_sat
    import sound_mixer_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc,
    input  logic        [VOL_W-1:0]    vol,
    output logic signed [SAMPLE_W-1:0] sat
);

    logic        [VOL_W:0]    gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted;

    always_comb begin
        gain    = {1'b0, vol} + 4'd1;
        prod    = PROD_W'(acc) * PROD_W'($signed({1'b0, gain}));
        shifted = ACC_W'(prod >>> 3);
        if (shifted > ACC_W'(SAT_MAX)) begin
            sat = SAT_MAX;
        end else if (shifted < ACC_W'(SAT_MIN)) begin
            sat = SAT_MIN;
        end else begin
            sat = SAMPLE_W'(shifted);
        end
    end

endmodule

// File: rtl/sound_mixer.sv
// Stereo mixer: snapshots four channel samples per strobe, routes them by NR51,
// scales by NR50 and gates on NR52 enable, one stereo pair per strobe.
//
//   state    | meaning
//   ST_IDLE  | waiting for strobe; snapshot inputs on strobe
//   ST_ACC   | add channel ch_idx (0..3) into left/right accumulators
//   ST_SCALE | volume scale + clamp, register outputs
//   ST_SAT   | outputs valid for one cycle, back to idle
module sound_mixer
    import sound_mixer_pkg::*;
(
    input  logic         I_CLK,
    input  logic         I_RESET_L,
    sound_mixer_if.slave bus
);

    mix_state_t                 state, state_nx;
    logic [1:0]                 ch_idx;
    logic signed [SAMPLE_W-1:0] snap_ch [NUM_CH];
    logic [7:0]                 snap_nr50;
    logic [7:0]                 snap_nr51;
    logic                       snap_en;
    logic signed [ACC_W-1:0]    left_acc, right_acc;
    logic signed [SAMPLE_W-1:0] left_sat, right_sat;
    logic [SAMPLE_W-1:0]        left_q, right_q;
    logic                       valid_q, overrun_q;
    logic [NUM_CH-1:0]          route_l, route_r;

    assign route_l = snap_nr51[NR51_L_LSB +: NUM_CH];
    assign route_r = snap_nr51[NR51_R_LSB +: NUM_CH];

    sound_mix_scale_sat u_scale_l (
        .acc (left_acc),
        .vol (snap_nr50[NR50_L_LSB +: VOL_W]),
        .sat (left_sat)
    );

    sound_mix_scale_sat u_scale_r (
        .acc (right_acc),
        .vol (snap_nr50[NR50_R_LSB +: VOL_W]),
        .sat (right_sat)
    );

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (bus.I_STROBE) state_nx = ST_ACC;
            ST_ACC:   if (ch_idx == 2'(NUM_CH - 1)) state_nx = ST_SCALE;
            ST_SCALE: state_nx = ST_SAT;
            ST_SAT:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            ch_idx    <= '0;
            for (int i = 0; i < NUM_CH; i++) snap_ch[i] <= '0;
            snap_nr50 <= '0;
            snap_nr51 <= '0;
            snap_en   <= 1'b0;
            left_acc  <= '0;
            right_acc <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // a strobe outside idle is dropped; the mix in flight is not disturbed
            if (bus.I_STROBE && state != ST_IDLE) overrun_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.I_STROBE) begin
                        snap_ch[0] <= bus.I_CH1_WAVEFORM;
                        snap_ch[1] <= bus.I_CH2_WAVEFORM;
                        snap_ch[2] <= bus.I_CH3_WAVEFORM;
                        snap_ch[3] <= bus.I_CH4_WAVEFORM;
                        snap_nr50  <= bus.I_NR50;
                        snap_nr51  <= bus.I_NR51;
                        snap_en    <= bus.I_NR52_EN;
                        left_acc   <= '0;
                        right_acc  <= '0;
                        ch_idx     <= '0;
                    end
                end
                ST_ACC: begin
                    if (route_l[ch_idx]) left_acc  <= left_acc  + sext_acc(snap_ch[ch_idx]);
                    if (route_r[ch_idx]) right_acc <= right_acc + sext_acc(snap_ch[ch_idx]);
                    ch_idx <= ch_idx + 2'd1;
                end
                ST_SCALE: begin
                    left_q  <= snap_en ? left_sat  : '0;
                    right_q <= snap_en ? right_sat : '0;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.O_LEFT    = left_q;
    assign bus.O_RIGHT   = right_q;
    assign bus.O_VALID   = valid_q;
    assign bus.O_OVERRUN = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer: a cycle-level reference model checked every
// cycle, plus hand-computed literal results for each directed mix.
module tb_sound_mixer;

    logic I_CLK     = 1'b0;
    logic I_RESET_L = 1'b1;

    sound_mixer_if bus();

    sound_mixer dut (
        .I_CLK     (I_CLK),
        .I_RESET_L (I_RESET_L),
        .bus       (bus)
    );

    always #5 I_CLK = ~I_CLK;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int cyc       = 0;
    int acc_edge  = -100;
    int due_edge  = -1;
    int pend_l    = 0;
    int pend_r    = 0;
    int exp_l     = 0;
    int exp_r     = 0;
    bit exp_valid = 1'b0;
    bit m_ovr     = 1'b0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check20(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
        end
    endtask

    // One output side: sum routed channels, multiply by vol+1, floor-divide by 8, clamp.
    function automatic int model_side(input logic [3:0] route, input logic [2:0] vol, input int s[4]);
        int sum;
        int gain;
        sum = 0;
        for (int i = 0; i < 4; i++) if (route[i]) sum += s[i];
        gain = int'(vol);
        gain = gain + 1;
        sum  = (sum * gain) >>> 3;
        if (sum > 524287)  sum = 524287;
        if (sum < -524288) sum = -524288;
        return sum;
    endfunction

    always @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            exp_valid = 1'b0;
            exp_l     = 0;
            exp_r     = 0;
            m_ovr     = 1'b0;
            acc_edge  = -100;
            due_edge  = -1;
        end else begin
            int s[4];
            cyc++;
            exp_valid = 1'b0;
            if (cyc == due_edge) begin
                exp_valid = 1'b1;
                exp_l     = pend_l;
                exp_r     = pend_r;
            end
            if (bus.I_STROBE) begin
                if (cyc - acc_edge <= 6) begin
                    m_ovr = 1'b1;
                end else begin
                    s[0] = int'($signed(bus.I_CH1_WAVEFORM));
                    s[1] = int'($signed(bus.I_CH2_WAVEFORM));
                    s[2] = int'($signed(bus.I_CH3_WAVEFORM));
                    s[3] = int'($signed(bus.I_CH4_WAVEFORM));
                    pend_l   = bus.I_NR52_EN ? model_side(bus.I_NR51[7:4], bus.I_NR50[6:4], s) : 0;
                    pend_r   = bus.I_NR52_EN ? model_side(bus.I_NR51[3:0], bus.I_NR50[2:0], s) : 0;
                    acc_edge = cyc;
                    due_edge = cyc + 5;
                end
            end
        end
    end

    always begin
        @(negedge I_CLK);
        #1;
        check_int("cmp_valid",   int'(bus.O_VALID),   int'(exp_valid));
        check_int("cmp_overrun", int'(bus.O_OVERRUN), int'(m_ovr));
        check20("cmp_left",  bus.O_LEFT,  20'(exp_l));
        check20("cmp_right", bus.O_RIGHT, 20'(exp_r));
    end

    task automatic set_inputs(input int c1, input int c2, input int c3, input int c4,
                              input logic [7:0] nr50, input logic [7:0] nr51, input logic en);
        bus.I_CH1_WAVEFORM = 20'(c1);
        bus.I_CH2_WAVEFORM = 20'(c2);
        bus.I_CH3_WAVEFORM = 20'(c3);
        bus.I_CH4_WAVEFORM = 20'(c4);
        bus.I_NR50         = nr50;
        bus.I_NR51         = nr51;
        bus.I_NR52_EN      = en;
    endtask

    // Called on a falling edge: strobe this cycle, expect one pulse six cycles later.
    task automatic fire_and_check(input string name, input logic [19:0] el, input logic [19:0] er);
        int lat;
        bit seen;
        bus.I_STROBE = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge I_CLK);
            lat++;
            bus.I_STROBE = 1'b0;
            if (bus.O_VALID) seen = 1'b1;
        end
        check_int({name, "_latency"}, seen ? lat : -1, 6);
        if (seen) begin
            check20({name, "_left"},  bus.O_LEFT,  el);
            check20({name, "_right"}, bus.O_RIGHT, er);
            @(negedge I_CLK);
            check_int({name, "_pulse_width"}, int'(bus.O_VALID), 0);
            check20({name, "_hold_left"}, bus.O_LEFT, el);
        end
    endtask

    task automatic run_mix(input string name, input logic [19:0] el, input logic [19:0] er);
        @(negedge I_CLK);
        fire_and_check(name, el, er);
    endtask

    initial begin
        int          nvalid;
        logic [19:0] vl;
        bus.I_STROBE = 1'b0;
        set_inputs(0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        #2 I_RESET_L = 1'b0;
        repeat (3) @(negedge I_CLK);
        check20("reset_left",  bus.O_LEFT,  20'h0);
        check20("reset_right", bus.O_RIGHT, 20'h0);
        check_int("reset_valid",   int'(bus.O_VALID),   0);
        check_int("reset_overrun", int'(bus.O_OVERRUN), 0);
        I_RESET_L = 1'b1;

        set_inputs(1000, 0, 0, 0, 8'h77, 8'h11, 1'b1);
        run_mix("t1_single", 20'd1000, 20'd1000);

        set_inputs(524287, 524287, 524287, 524287, 8'h77, 8'hFF, 1'b1);
        run_mix("t2_sat_pos", 20'h7FFFF, 20'h7FFFF);
        set_inputs(-524288, -524288, -524288, -524288, 8'h77, 8'hFF, 1'b1);
        run_mix("t2_sat_neg", 20'h80000, 20'h80000);

        set_inputs(800, -200, 0, 0, 8'h30, 8'h12, 1'b1);
        run_mix("t3_vol", 20'd400, 20'hFFFE7);

        set_inputs(1000, 0, 0, 0, 8'h77, 8'h11, 1'b0);
        run_mix("t4_disabled", 20'h0, 20'h0);

        set_inputs(1000, 500, 0, 0, 8'h77, 8'h00, 1'b1);
        run_mix("t4_no_route", 20'h0, 20'h0);

        // left: (200+7)*6>>3 = 155, right: (100-50)*3>>3 = 18
        set_inputs(100, 200, -50, 7, 8'h52, 8'hA5, 1'b1);
        run_mix("t_mixed", 20'd155, 20'd18);

        set_inputs(1000, 0, 0, 0, 8'h77, 8'h11, 1'b1);
        @(negedge I_CLK);
        bus.I_STROBE = 1'b1;
        nvalid = 0;
        vl     = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge I_CLK);
            bus.I_STROBE = (i == 3);
            if (i == 1) bus.I_CH1_WAVEFORM = 20'd2000;
            if (bus.O_VALID) begin
                nvalid++;
                vl = bus.O_LEFT;
            end
        end
        check_int("t5_valid_count", nvalid, 1);
        check20("t5_first_left", vl, 20'd1000);
        check_int("t5_overrun", int'(bus.O_OVERRUN), 1);
        run_mix("t5_next", 20'd2000, 20'd2000);
        check_int("t5_overrun_sticky", int'(bus.O_OVERRUN), 1);

        set_inputs(800, -200, 0, 0, 8'h30, 8'h12, 1'b1);
        @(negedge I_CLK);
        bus.I_STROBE = 1'b1;
        nvalid = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge I_CLK);
            bus.I_STROBE = 1'b0;
            if (i == 4) I_RESET_L = 1'b0;
            if (bus.O_VALID) nvalid++;
        end
        check_int("t6_no_valid", nvalid, 0);
        check20("t6_rst_left",  bus.O_LEFT,  20'h0);
        check20("t6_rst_right", bus.O_RIGHT, 20'h0);
        check_int("t6_rst_overrun", int'(bus.O_OVERRUN), 0);
        @(negedge I_CLK);
        I_RESET_L = 1'b1;
        fire_and_check("t6_after_reset", 20'd400, 20'hFFFE7);

        repeat (3) @(negedge I_CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
